// File: rtl/mi_word_stream_reader_if.sv
// Stream-reader bus: start/status, the RAM read port and the output word stream.
// The reader holds the master modport; whoever drives start, feeds the RAM q
// and consumes the words holds the slave modport.
interface mi_word_stream_reader_if #(
   parameter int K      = 128,
   parameter int N      = 32,
   parameter int ADDR_W = (N > 1) ? $clog2(N) : 1
);
   logic              rd_start;
   logic              rd_busy;
   logic              rd_done;
   logic [ADDR_W-1:0] ram_rd_addr;
   logic [K-1:0]      ram_rd_data;
   logic [K-1:0]      r;
   logic              valid_out;
   logic              ready_in;
   logic              last_out;
   logic [ADDR_W-1:0] word_idx;

   modport master (
      input  rd_start, ram_rd_data, ready_in,
      output rd_busy, rd_done, ram_rd_addr, r, valid_out, last_out, word_idx
   );

   modport slave (
      output rd_start, ram_rd_data, ready_in,
      input  rd_busy, rd_done, ram_rd_addr, r, valid_out, last_out, word_idx
   );
endinterface

// File: rtl/mi_word_stream_reader.sv
// Streams an N-word operand out of a word RAM, least-significant word first.
// The RAM has one cycle of registered read latency; a 4-entry prefetch FIFO
// hides it so that the stream sustains one word per cycle and backpressure
// never loses a word.
//
// Handshake: a word moves on every rising edge where valid_out & ready_in.
// Once valid_out is raised it stays high, and r/word_idx/last_out stay
// unchanged, until that word has been transferred.
module mi_word_stream_reader #(
   parameter int K      = 128,
   parameter int N      = 32,
   parameter int ADDR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   mi_word_stream_reader_if.master bus,
   output logic [1:0]              dbg_state
);
   // Wide enough to count up to N inclusive
   localparam int CNT_W = $clog2(N + 1);
   localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(N);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state;
   logic              rd_busy_q;
   logic              rd_done_q;

   // Address issue side
   logic [CNT_W-1:0]  issue_cnt;
   logic [ADDR_W-1:0] addr_q;
   logic              iss_d1;   // address register holds an issued address
   logic              iss_d2;   // RAM q holds the word for that address

   // Prefetch FIFO
   logic [K-1:0]      fifo_data [4];
   logic [ADDR_W-1:0] fifo_idx  [4];
   logic [3:0]        fifo_last;
   logic [1:0]        wr_ptr;
   logic [1:0]        rd_ptr;
   logic [2:0]        occ;
   logic [CNT_W-1:0]  cap_cnt;

   logic              start_acc;
   logic [1:0]        in_flight;
   logic [2:0]        pending;
   logic              issue;
   logic              cap;
   logic              valid;
   logic              xfer;
   logic              last_xfer;

   // Issue/capture/transfer decisions for the current cycle
   always_comb begin
      start_acc = (state == S_IDLE) && bus.rd_start;
      in_flight = {1'b0, iss_d1} + {1'b0, iss_d2};
      pending   = occ + {1'b0, in_flight};
      // The first address goes out on the start edge itself; afterwards only
      // as long as every outstanding word is guaranteed a FIFO slot.
      issue     = start_acc ||
                  ((state == S_READ) && (issue_cnt < N_CNT) && (pending < 3'd4));
      cap       = iss_d2;
      valid     = (occ != 3'd0);
      xfer      = valid && bus.ready_in;
      last_xfer = xfer && fifo_last[rd_ptr];
   end

   // Control FSM with registered busy/done flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         rd_busy_q <= 1'b0;
         rd_done_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               rd_done_q <= 1'b0;
               if (bus.rd_start) begin
                  state     <= S_READ;
                  rd_busy_q <= 1'b1;
               end
            end
            S_READ: begin
               if (last_xfer) begin
                  state     <= S_DONE;
                  rd_busy_q <= 1'b0;
                  rd_done_q <= 1'b1;
               end
            end
            S_DONE: begin
               state     <= S_IDLE;
               rd_done_q <= 1'b0;
            end
            default: begin
               state     <= S_IDLE;
               rd_busy_q <= 1'b0;
               rd_done_q <= 1'b0;
            end
         endcase
      end
   end

   // Address counter and the two-stage tracker of words in flight in the RAM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_cnt <= '0;
         addr_q    <= '0;
         iss_d1    <= 1'b0;
         iss_d2    <= 1'b0;
      end else begin
         iss_d1 <= issue;
         iss_d2 <= iss_d1;
         if (start_acc) begin
            issue_cnt <= CNT_W'(1);
            addr_q    <= '0;
         end else if (issue) begin
            issue_cnt <= issue_cnt + CNT_W'(1);
            addr_q    <= issue_cnt[ADDR_W-1:0];
         end
      end
   end

   // Prefetch FIFO: capture RAM q two edges after issue, pop on transfer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            fifo_data[i] <= '0;
            fifo_idx[i]  <= '0;
         end
         fifo_last <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occ       <= '0;
         cap_cnt   <= '0;
      end else begin
         if (start_acc) begin
            cap_cnt <= '0;
         end else if (cap) begin
            fifo_data[wr_ptr] <= bus.ram_rd_data;
            fifo_idx[wr_ptr]  <= cap_cnt[ADDR_W-1:0];
            fifo_last[wr_ptr] <= (cap_cnt == LAST_CNT);
            wr_ptr            <= wr_ptr + 2'd1;
            cap_cnt           <= cap_cnt + CNT_W'(1);
         end
         if (xfer) begin
            rd_ptr <= rd_ptr + 2'd1;
         end
         case ({cap, xfer})
            2'b10:   occ <= occ + 3'd1;
            2'b01:   occ <= occ - 3'd1;
            default: occ <= occ;
         endcase
      end
   end

   // A capture into a full FIFO would silently drop a word
   always_ff @(posedge clk) begin
      if (!rst && cap && !xfer) begin
         assert (occ < 3'd4);
      end
   end

   assign bus.rd_busy     = rd_busy_q;
   assign bus.rd_done     = rd_done_q;
   assign bus.ram_rd_addr = addr_q;
   assign bus.r           = fifo_data[rd_ptr];
   assign bus.word_idx    = fifo_idx[rd_ptr];
   assign bus.last_out    = fifo_last[rd_ptr];
   assign bus.valid_out   = valid;
   assign dbg_state       = state;
endmodule

// File: tb/tb_mi_word_stream_reader.sv
// Bench for mi_word_stream_reader: a 32-word instance driven through
// full-rate, stalled, random-backpressure, repeated-start and mid-stream reset
// scenarios, plus a 1-word instance for the single-word corner.
module tb_mi_word_stream_reader;
  localparam int K    = 128;
  localparam int NA   = 32;
  localparam int NB   = 1;
  localparam int AW_A = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- DUTs and RAM models ----------------
  mi_word_stream_reader_if #(.K(K), .N(NA)) bus_a ();
  mi_word_stream_reader_if #(.K(K), .N(NB)) bus_b ();
  logic [1:0] dbg_a;
  logic [1:0] dbg_b;

  mi_word_stream_reader #(.K(K), .N(NA)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .dbg_state(dbg_a)
  );
  mi_word_stream_reader #(.K(K), .N(NB)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .dbg_state(dbg_b)
  );

  logic [K-1:0] mem_a [NA];
  logic [K-1:0] mem_b0;

  always @(posedge clk) bus_a.ram_rd_data <= mem_a[bus_a.ram_rd_addr];
  always @(posedge clk) bus_b.ram_rd_data <= (bus_b.ram_rd_addr == 1'b0) ? mem_b0 : '0;

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [K-1:0] act, input logic [K-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: an operand is simply the RAM image, word 0 first
  logic [K-1:0] exp_q[$];
  int           exp_idx   = 0;
  int           xfer_cnt  = 0;
  int           done_cnt  = 0;
  int           done_cyc  = 0;
  int           start_cyc = 0;
  logic [K-1:0] last_word = '0;
  bit           hold_prev = 1'b0;
  logic [K-1:0] prev_r;
  logic [AW_A-1:0] prev_idx;
  logic         prev_last;

  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (bus_a.rd_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (hold_prev) begin
        check("stall_valid", K'(bus_a.valid_out), K'(1));
        check("stall_r", bus_a.r, prev_r);
        check("stall_idx", K'(bus_a.word_idx), K'(prev_idx));
        check("stall_last", K'(bus_a.last_out), K'(prev_last));
      end
      if (bus_a.valid_out && bus_a.ready_in) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_word: got r=%0h expected no word", bus_a.r);
        end else begin
          check("word_r", bus_a.r, exp_q.pop_front());
          check("word_idx", K'(bus_a.word_idx), K'(exp_idx));
          check("word_last", K'(bus_a.last_out), K'(exp_idx == NA - 1));
          if (bus_a.last_out) last_word = bus_a.r;
          exp_idx++;
          xfer_cnt++;
        end
      end
      hold_prev = bus_a.valid_out && !bus_a.ready_in;
      prev_r    = bus_a.r;
      prev_idx  = bus_a.word_idx;
      prev_last = bus_a.last_out;
    end
  end

  // ---------------- driver tasks ----------------
  // Returns just after edge E0, the edge that samples rd_start
  task automatic start_a();
    @(posedge clk); #1;
    bus_a.rd_start = 1'b1;
    @(posedge clk); #1;
    bus_a.rd_start = 1'b0;
    start_cyc = cyc;
    xfer_cnt  = 0;
    exp_idx   = 0;
    for (int i = 0; i < NA; i++) exp_q.push_back(mem_a[i]);
  endtask

  task automatic wait_done_a(input bit rnd, input bit poke_start);
    bit ok = 1'b0;
    int n  = 0;
    while (n < 3000) begin
      @(negedge clk);
      if (bus_a.rd_done) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      n++;
      if (rnd) bus_a.ready_in = 1'($urandom_range(0, 1));
      if (poke_start) bus_a.rd_start = (n < 20) && (n % 2 == 1);
    end
    bus_a.rd_start = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no rd_done expected rd_done within 3000 cycles");
    end
  endtask

  task automatic check_stream_end(input string tag, input int done_before);
    check({tag, "_count"}, K'(xfer_cnt), K'(NA));
    check({tag, "_leftover"}, K'(exp_q.size()), K'(0));
    check({tag, "_done_pulses"}, K'(done_cnt - done_before), K'(1));
    check({tag, "_busy_after"}, K'(bus_a.rd_busy), K'(0));
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int d0;
    bit found;
    for (int i = 0; i < NA; i++) mem_a[i] = 128'h1000 + K'(i);
    mem_b0 = 128'hDEAD;
    bus_a.rd_start = 1'b0;
    bus_a.ready_in = 1'b0;
    bus_b.rd_start = 1'b0;
    bus_b.ready_in = 1'b0;

    // Reset state
    #2;
    check("rst_r", bus_a.r, '0);
    check("rst_valid", K'(bus_a.valid_out), K'(0));
    check("rst_busy", K'(bus_a.rd_busy), K'(0));
    check("rst_done", K'(bus_a.rd_done), K'(0));
    check("rst_addr", K'(bus_a.ram_rd_addr), K'(0));
    check("rst_idx", K'(bus_a.word_idx), K'(0));
    check("rst_last", K'(bus_a.last_out), K'(0));
    check("rst_state", K'(dbg_a), K'(0));
    check("rst_b_valid", K'(bus_b.valid_out), K'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Full-rate stream: first word valid after E2, done seen after E(N+2)
    bus_a.ready_in = 1'b1;
    d0 = done_cnt;
    start_a();
    @(negedge clk);
    check("t1_addr_e0", K'(bus_a.ram_rd_addr), K'(0));
    check("t1_busy_e0", K'(bus_a.rd_busy), K'(1));
    check("t1_valid_e0", K'(bus_a.valid_out), K'(0));
    @(negedge clk);
    check("t1_valid_e1", K'(bus_a.valid_out), K'(0));
    @(negedge clk);
    check("t1_valid_e2", K'(bus_a.valid_out), K'(1));
    check("t1_first_r", bus_a.r, 128'h1000);
    check("t1_first_idx", K'(bus_a.word_idx), K'(0));
    wait_done_a(1'b0, 1'b0);
    @(negedge clk);
    check("t1_done_cycle", K'(done_cyc - start_cyc), K'(34));
    check("t1_done_width", K'(bus_a.rd_done), K'(0));
    check("t1_last_word", last_word, 128'h101F);
    check_stream_end("t1", d0);

    // Stalled start: exactly addresses 0..3 issued, head word held
    bus_a.ready_in = 1'b0;
    d0 = done_cnt;
    start_a();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 3) check("t2_addr_hold", K'(bus_a.ram_rd_addr), K'(3));
      if (i >= 2) begin
        check("t2_valid_hold", K'(bus_a.valid_out), K'(1));
        check("t2_r_hold", bus_a.r, 128'h1000);
      end
    end
    @(posedge clk); #1;
    bus_a.ready_in = 1'b1;
    wait_done_a(1'b0, 1'b0);
    @(negedge clk);
    check_stream_end("t2", d0);

    // Random backpressure over several operands
    for (int op = 0; op < 8; op++) begin
      d0 = done_cnt;
      bus_a.ready_in = 1'($urandom_range(0, 1));
      start_a();
      wait_done_a(1'b1, 1'b0);
      @(negedge clk);
      check_stream_end("t3", d0);
    end

    // Repeated rd_start while streaming is ignored
    bus_a.ready_in = 1'b1;
    d0 = done_cnt;
    start_a();
    wait_done_a(1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check_stream_end("t4", d0);
    check("t4_idle_valid", K'(bus_a.valid_out), K'(0));

    // Reset while word 7 is on the output
    d0 = done_cnt;
    start_a();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (bus_a.valid_out && bus_a.word_idx == AW_A'(7)) found = 1'b1;
    end
    check("t5_reached_7", K'(found), K'(1));
    #2 rst = 1'b1;
    #1;
    check("t5_r", bus_a.r, '0);
    check("t5_valid", K'(bus_a.valid_out), K'(0));
    check("t5_busy", K'(bus_a.rd_busy), K'(0));
    check("t5_addr", K'(bus_a.ram_rd_addr), K'(0));
    check("t5_idx", K'(bus_a.word_idx), K'(0));
    check("t5_last", K'(bus_a.last_out), K'(0));
    check("t5_state", K'(dbg_a), K'(0));
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_no_done", K'(done_cnt - d0), K'(0));
    check("t5_idle_valid", K'(bus_a.valid_out), K'(0));
    d0 = done_cnt;
    start_a();
    wait_done_a(1'b0, 1'b0);
    @(negedge clk);
    check_stream_end("t5", d0);

    // Single-word operand
    bus_b.ready_in = 1'b1;
    @(posedge clk); #1;
    bus_b.rd_start = 1'b1;
    @(posedge clk); #1;
    bus_b.rd_start = 1'b0;
    @(negedge clk);
    check("t6_valid_e0", K'(bus_b.valid_out), K'(0));
    check("t6_busy_e0", K'(bus_b.rd_busy), K'(1));
    @(negedge clk);
    check("t6_valid_e1", K'(bus_b.valid_out), K'(0));
    @(negedge clk);
    check("t6_valid_e2", K'(bus_b.valid_out), K'(1));
    check("t6_r", bus_b.r, 128'hDEAD);
    check("t6_last", K'(bus_b.last_out), K'(1));
    check("t6_idx", K'(bus_b.word_idx), K'(0));
    check("t6_done_early", K'(bus_b.rd_done), K'(0));
    @(negedge clk);
    check("t6_done", K'(bus_b.rd_done), K'(1));
    check("t6_valid_after", K'(bus_b.valid_out), K'(0));
    check("t6_busy_after", K'(bus_b.rd_busy), K'(0));
    @(negedge clk);
    check("t6_done_width", K'(bus_b.rd_done), K'(0));

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mi_word_stream_reader.md
Name: mi_word_stream_reader

Overview:
- Unloads an N-word, K-bit-per-word operand or result from a simple_ram-style word RAM. Words are streamed out least-significant word first over a valid/ready handshake.
- It is the read-out counterpart of the modular-inverse word loader, which writes N words on valid_in into RAM.
- It sits between the inverse/exponentiation datapath RAMs (u, v, A, B, C, D) and downstream consumers.
- It hides the RAM's one-cycle registered read latency behind a 4-entry prefetch buffer, so downstream backpressure never loses data.

Parameters:
- K, 128, word width in bits.
- N, 32, number of words per operand; must be >= 1.
- ADDR_W, $clog2(N) (minimum 1), RAM address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- rd_start  in  1  start pulse; sampled only in IDLE.
- rd_busy  out  1  high from the cycle after start acceptance until the done pulse.
- rd_done  out  1  one-cycle pulse after the last word is accepted downstream.
- ram_rd_addr  out  ADDR_W  registered read address to the RAM.
- ram_rd_data  in  K  RAM q; valid one clock after ram_rd_addr changes.
- r  out  K  output word.
- valid_out  out  1  r is valid.
- ready_in  in  1  downstream accepts r when valid_out & ready_in.
- last_out  out  1  high with word N-1.
- word_idx  out  ADDR_W  index of the word currently on r.

Behaviour:
- Clock and reset: one clock domain (clk). rst is asynchronous and active-high.
- Reset values: all outputs 0 (rd_busy, rd_done, ram_rd_addr, r, valid_out, last_out, word_idx). State is IDLE, and all counters and buffer pointers are 0.
- States:
  - IDLE: on rd_start, go to READ. Clear issue_cnt, in_flight, occupancy and the accepted counter.
  - READ: issue addresses, capture RAM data into the buffer and serve handshakes. When word N-1 is transferred, go to DONE.
  - DONE: one cycle; rd_done=1, rd_busy=0; return to IDLE.
- Start handling: rd_start in READ or DONE is ignored; no queuing.
- Issue rule:
  - In READ, drive ram_rd_addr = issue_cnt and increment issue_cnt in any cycle where issue_cnt < N and occupancy + in_flight < 4.
  - in_flight counts issued addresses not yet captured (max 2).
  - A word is captured into the buffer two edges after its issue edge: one edge for the address register, one for the RAM q.
- ram_rd_addr holds its last value when not issuing.
- Buffer: 4-entry FIFO. Capture and transfer in the same cycle leave occupancy unchanged. Overflow is impossible by the issue rule and must be asserted against in simulation.
- Output handshake:
  - valid_out = (occupancy != 0). r, last_out and word_idx come from the FIFO head.
  - While valid_out & !ready_in, r, word_idx and last_out must stay stable.
  - valid_out never drops without a transfer.
- Latency: rd_start is sampled at edge E0 and ram_rd_addr=0 appears after E0. The word arrives on q after E1, is captured at E2, and valid_out is high after E2.
- Throughput: with ready_in held high, one word per cycle sustained. Total start-to-done is N+3 cycles.
- Boundary cases:
  - N=1: last_out=1 on the first word.
  - ready_in low from start: exactly 4 addresses (0..3) are issued, then ram_rd_addr holds 3 until a transfer frees space.
  - Wrap-around: word_idx never wraps within an operand.
  - Reset mid-operation: everything returns to reset values immediately. Partially buffered words are discarded and no rd_done is produced.

Test Plan:
- RAM preloaded with word i = 128'h1000+i, N=32, ready_in=1, rd_start pulse -> valid_out rises after E2; 32 consecutive transfers with r=1000..101F; last_out only on 101F; rd_done pulse at cycle 35; rd_busy low afterwards.
- Same preload, ready_in=0 for 10 cycles after start -> ram_rd_addr stops at 3; r=1000 held stable with valid_out=1; after ready_in rises, all 32 words arrive in order with no loss or duplication.
- Random ready_in (50%), 1000 operands -> word order and count match the RAM image; valid_out never drops without a transfer; FIFO overflow assertion never fires.
- rst asserted when word_idx=7 -> all outputs 0 asynchronously; no rd_done; a new rd_start afterwards streams from word 0.
- rd_start pulsed repeatedly during READ -> ignored; exactly one N-word stream and one rd_done.
- N=1, word 0 = 128'hDEAD -> single transfer r=DEAD with last_out=1; rd_done the cycle after acceptance.
